output_port_arbiter: RTL and testbench

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

---
 rtl/output_port_arbiter_pkg.sv | 28 ++
 rtl/output_port_arbiter_if.sv | 28 ++
 rtl/output_port_arbiter_rr_arbiter.sv | 32 +++
 rtl/output_port_arbiter.sv | 121 ++++++++++++
 tb/tb_output_port_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared NoC constants and types: flit type encoding and arbiter FSM states.
// Imported by the output-port arbiter and by the input router.
package output_port_arbiter_pkg;

  localparam int DEF_NUM_PORTS = 5;
  localparam int DEF_FLIT_W    = 34;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic isHead(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic isTail(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input routers, the output-port arbiter and the output link.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface output_port_arbiter_if #(
  parameter int NUM_PORTS = output_port_arbiter_pkg::DEF_NUM_PORTS,
  parameter int FLIT_W    = output_port_arbiter_pkg::DEF_FLIT_W
);

  logic [NUM_PORTS-1:0]        req_i;
  logic [NUM_PORTS-1:0]        valid_i;
  logic [NUM_PORTS*FLIT_W-1:0] flit_i;
  logic [NUM_PORTS-1:0]        ready_o;
  logic [FLIT_W-1:0]           flit_o;
  logic                        valid_o;
  logic                        ready_i;
  logic [NUM_PORTS-1:0]        grant_o;
  logic                        err_o;

  modport slave (
    input  req_i, valid_i, flit_i, ready_i,
    output ready_o, flit_o, valid_o, grant_o, err_o
  );

  modport master (
    output req_i, valid_i, flit_i, ready_i,
    input  ready_o, flit_o, valid_o, grant_o, err_o
  );

endinterface

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational round-robin search: one-hot grant to the first request found
// scanning upward from (ptr_i + 1) modulo N.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [PTR_W:0] cand;
  logic           found;

  // ptr_i < N and k <= N, so one conditional subtract is enough for the wrap
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N)) begin
        cand = cand - (PTR_W+1)'(N);
      end
      if (!found && req_i[cand[PTR_W-1:0]]) begin
        grant_o[cand[PTR_W-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: locks the output link to one input from HEAD to TAIL,
// with round-robin selection among new packet heads.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int FLIT_W    = DEF_FLIT_W
) (
  input  logic                 clk,
  input  logic                 arst,
  output_port_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_PORTS - 1);

  arb_state_e           state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] grant_d;
  logic [PTR_W-1:0]     ptr_q;
  logic                 err_q;
  logic                 err_d;
  logic                 first_q;

  logic [NUM_PORTS-1:0] eligible;
  logic                 badIdle;
  logic [PTR_W-1:0]     grantIdx;
  logic [FLIT_W-1:0]    flitOut;
  logic                 validOut;
  logic [NUM_PORTS-1:0] readyOut;
  logic [1:0]           outType;
  logic                 xfer;

  always_comb begin
    eligible = '0;
    badIdle  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.req_i[i] && bus.valid_i[i]) begin
        if (isHead(bus.flit_i[i*FLIT_W + FLIT_W - 1 -: 2])) begin
          eligible[i] = 1'b1;
        end else begin
          badIdle = 1'b1;
        end
      end
    end
  end

  rr_arbiter #(
    .N     (NUM_PORTS),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (grant_d)
  );

  // Outputs are forced quiet while reset is asserted so an abandoned packet never leaks a flit
  always_comb begin
    grantIdx = '0;
    flitOut  = '0;
    validOut = 1'b0;
    readyOut = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        grantIdx = PTR_W'(i);
      end
    end
    if ((state_q == ST_LOCKED) && !arst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_q[i]) begin
          flitOut  = bus.flit_i[i*FLIT_W +: FLIT_W];
          validOut = bus.valid_i[i] & bus.req_i[i];
        end
      end
      readyOut = grant_q & {NUM_PORTS{bus.ready_i}};
    end
    outType = flitOut[FLIT_W-1 -: 2];
    xfer    = validOut & bus.ready_i;
    err_d   = ((state_q == ST_IDLE) && badIdle) ||
              (xfer && !first_q && (outType == FLIT_HEAD));
  end

  // first_q marks that the packet's opening HEAD has not yet crossed the link
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RESET;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (|eligible) begin
            state_q <= ST_LOCKED;
            grant_q <= grant_d;
            first_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (xfer) begin
            first_q <= 1'b0;
            if (isTail(outType)) begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              ptr_q   <= grantIdx;
            end
          end
        end
      endcase
    end
  end

  assign bus.flit_o  = flitOut;
  assign bus.valid_o = validOut;
  assign bus.ready_o = readyOut;
  assign bus.grant_o = grant_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Table-driven bench for output_port_arbiter with a scoreboard of forwarded flits.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;

  localparam int NP = 5;
  localparam int FW = 34;

  localparam logic [1:0] H = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] T = 2'b10;
  localparam logic [1:0] X = 2'b11;

  typedef struct {
    logic        arst;
    logic [4:0]  req;
    logic [4:0]  vld;
    logic [9:0]  ty;
    logic        rdy;
    logic [4:0]  expGrant;
    logic        expValid;
    logic [4:0]  expReady;
    logic        expErr;
    int          expSrc;
  } vec_t;

  vec_t          vecs[$];
  logic [FW-1:0] sbQueue[$];
  int            total = 0;
  int            bad   = 0;

  logic clk = 1'b0;
  logic arst;

  output_port_arbiter_if #(.NUM_PORTS(NP), .FLIT_W(FW)) bus ();

  output_port_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] tys(input logic [1:0] t0, input logic [1:0] t1,
                                     input logic [1:0] t2, input logic [1:0] t3,
                                     input logic [1:0] t4);
    return {t4, t3, t2, t1, t0};
  endfunction

  function automatic logic [FW-1:0] mkFlit(input int p, input int row, input logic [1:0] t);
    logic [31:0] payload;
    payload = 32'hC0DE_0000 | (32'(p) << 8) | 32'(row);
    return {t, payload};
  endfunction

  task automatic addRow(input logic a, input logic [4:0] rq, input logic [4:0] vl,
                        input logic [9:0] ty, input logic rd, input logic [4:0] eg,
                        input logic ev, input logic [4:0] er, input logic ee, input int es);
    vec_t v;
    v.arst = a; v.req = rq; v.vld = vl; v.ty = ty; v.rdy = rd;
    v.expGrant = eg; v.expValid = ev; v.expReady = er; v.expErr = ee; v.expSrc = es;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input int idx, input logic [63:0] act,
                          input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [NP*FW-1:0] f;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      f[p*FW +: FW] = mkFlit(p, idx, v.ty[2*p +: 2]);
    end
    arst        = v.arst;
    bus.req_i   = v.req;
    bus.valid_i = v.vld;
    bus.flit_i  = f;
    bus.ready_i = v.rdy;
    if (v.expValid && v.rdy && (v.expSrc >= 0)) begin
      sbQueue.push_back(mkFlit(v.expSrc, idx, v.ty[2*v.expSrc +: 2]));
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [FW-1:0] expFlit;
    @(negedge clk);
    expFlit = (v.expSrc < 0) ? '0 : mkFlit(v.expSrc, idx, v.ty[2*v.expSrc +: 2]);
    checkVal("grant", idx, 64'(bus.grant_o), 64'(v.expGrant));
    checkVal("valid", idx, 64'(bus.valid_o), 64'(v.expValid));
    checkVal("ready", idx, 64'(bus.ready_o), 64'(v.expReady));
    checkVal("err",   idx, 64'(bus.err_o),   64'(v.expErr));
    checkVal("flit",  idx, 64'(bus.flit_o),  64'(expFlit));
    if (bus.valid_o && bus.ready_i) begin
      if (sbQueue.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_unexpected row %0d: got flit %h expected no transfer", idx, bus.flit_o);
      end else begin
        checkVal("sb_flit", idx, 64'(bus.flit_o), 64'(sbQueue.pop_front()));
      end
    end
  endtask

  initial begin
    arst        = 1'b1;
    bus.req_i   = '0;
    bus.valid_i = '0;
    bus.flit_i  = '0;
    bus.ready_i = 1'b0;

    // single HEAD_TAIL packet on input 2
    addRow(0, 5'b00100, 5'b00100, tys(H,H,X,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00100, 5'b00100, tys(H,H,X,H,H), 1, 5'b00100, 1, 5'b00100, 0,  2);
    addRow(0, 5'b00000, 5'b00010, tys(H,B,H,H,H), 0, 5'b00000, 0, 5'b00000, 0, -1);
    // reset, then inputs 1 and 3 contend; 1 wins, 3 follows after the tail
    addRow(1, 5'b00000, 5'b00000, tys(H,H,H,H,H), 0, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b01010, 5'b01010, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b01010, 5'b01010, tys(H,H,H,H,H), 1, 5'b00010, 1, 5'b00010, 0,  1);
    addRow(0, 5'b01010, 5'b01010, tys(H,T,H,H,H), 1, 5'b00010, 1, 5'b00010, 0,  1);
    addRow(0, 5'b01000, 5'b01000, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b01000, 5'b01000, tys(H,H,H,X,H), 1, 5'b01000, 1, 5'b01000, 0,  3);
    addRow(0, 5'b00000, 5'b00000, tys(H,H,H,H,H), 0, 5'b00000, 0, 5'b00000, 0, -1);
    // input 0 four-flit packet with ready toggling while input 2 waits
    addRow(0, 5'b00101, 5'b00101, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00101, 5'b00101, tys(H,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00101, 5'b00101, tys(B,H,H,H,H), 0, 5'b00001, 1, 5'b00000, 0,  0);
    addRow(0, 5'b00101, 5'b00101, tys(B,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00101, 5'b00101, tys(B,H,H,H,H), 0, 5'b00001, 1, 5'b00000, 0,  0);
    addRow(0, 5'b00101, 5'b00101, tys(B,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00101, 5'b00101, tys(T,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00100, 5'b00100, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    // tail coincides with a new head on input 4: one idle bubble
    addRow(0, 5'b00100, 5'b00100, tys(H,H,H,H,H), 1, 5'b00100, 1, 5'b00100, 0,  2);
    addRow(0, 5'b10100, 5'b10100, tys(H,H,T,H,H), 1, 5'b00100, 1, 5'b00100, 0,  2);
    addRow(0, 5'b10000, 5'b10000, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b10000, 5'b10000, tys(H,H,H,H,X), 1, 5'b10000, 1, 5'b10000, 0,  4);
    addRow(0, 5'b00000, 5'b00000, tys(H,H,H,H,H), 0, 5'b00000, 0, 5'b00000, 0, -1);
    // BODY presented while idle raises err, no grant
    addRow(0, 5'b00010, 5'b00010, tys(H,B,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00010, 5'b00010, tys(H,X,H,H,H), 1, 5'b00000, 0, 5'b00000, 1, -1);
    addRow(0, 5'b00010, 5'b00010, tys(H,X,H,H,H), 1, 5'b00010, 1, 5'b00010, 0,  1);
    // reset mid-packet on input 3, then inputs 0 and 2 contend: 0 wins
    addRow(0, 5'b01000, 5'b01000, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b01000, 5'b01000, tys(H,H,H,H,H), 1, 5'b01000, 1, 5'b01000, 0,  3);
    addRow(1, 5'b01000, 5'b01000, tys(H,H,H,B,H), 1, 5'b01000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00101, 5'b00101, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00101, 5'b00101, tys(H,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00101, 5'b00101, tys(T,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00100, 5'b00100, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00100, 5'b00100, tys(H,H,X,H,H), 1, 5'b00100, 1, 5'b00100, 0,  2);
    addRow(0, 5'b00000, 5'b00000, tys(H,H,H,H,H), 0, 5'b00000, 0, 5'b00000, 0, -1);
    // valid gap holds the lock; a second HEAD mid-packet raises err but is forwarded
    addRow(0, 5'b00001, 5'b00001, tys(H,H,H,H,H), 1, 5'b00000, 0, 5'b00000, 0, -1);
    addRow(0, 5'b00001, 5'b00001, tys(H,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00001, 5'b00000, tys(B,H,H,H,H), 1, 5'b00001, 0, 5'b00001, 0,  0);
    addRow(0, 5'b00001, 5'b00001, tys(H,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 0,  0);
    addRow(0, 5'b00001, 5'b00001, tys(T,H,H,H,H), 1, 5'b00001, 1, 5'b00001, 1,  0);
    addRow(0, 5'b00000, 5'b00000, tys(H,H,H,H,H), 0, 5'b00000, 0, 5'b00000, 0, -1);

    repeat (2) @(posedge clk);
    $display("[TB] applying %0d vectors", vecs.size());
    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r], r);
      checkOutput(vecs[r], r);
    end

    checkVal("sb_empty", vecs.size(), 64'(sbQueue.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
